// File: rtl/gpio_pkg.sv
// Shared GPIO register-bus definitions: register indices and bus-master FSM encoding.
package gpio_pkg;

   localparam logic [1:0] GPIO_IN0  = 2'd0;
   localparam logic [1:0] GPIO_IN1  = 2'd1;
   localparam logic [1:0] GPIO_OUT0 = 2'd2;
   localparam logic [1:0] GPIO_OUT1 = 2'd3;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WRITE     = 2'd1;
   localparam logic [1:0] ST_READ_WAIT = 2'd2;
   localparam logic [1:0] ST_RESP      = 2'd3;

   typedef enum logic [1:0] {
      IDLE      = ST_IDLE,
      WRITE     = ST_WRITE,
      READ_WAIT = ST_READ_WAIT,
      RESP      = ST_RESP
   } gpio_bm_state_t;

endpackage

// File: rtl/gpio_bus_master.sv
// GPIO register-bus initiator: one command in flight, registered bus outputs,
// fixed-latency read sampling and a single registered response per command.
module gpio_bus_master
   import gpio_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [1:0]        cmd_reg,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              bus_we,
   output logic [1:0]        bus_addr,
   output logic [DATA_W-1:0] bus_wd,
   input  logic [DATA_W-1:0] bus_rd
);

   localparam int CW = $clog2(READ_LAT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(READ_LAT - 1);

   gpio_bm_state_t    state, state_nx;
   logic [CW-1:0]     cnt, cnt_nx;
   logic              bus_we_nx, rsp_valid_nx, rsp_err_nx;
   logic [1:0]        bus_addr_nx;
   logic [DATA_W-1:0] bus_wd_nx, rsp_rdata_nx;
   logic              acc;

   assign cmd_ready = (state == IDLE) && !rst;
   assign acc       = cmd_valid && cmd_ready;

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      bus_we_nx    = 1'b0;
      bus_addr_nx  = bus_addr;
      bus_wd_nx    = bus_wd;
      rsp_valid_nx = rsp_valid;
      rsp_rdata_nx = rsp_rdata;
      rsp_err_nx   = rsp_err;
      case (state)
         IDLE: begin
            if (acc) begin
               bus_addr_nx = cmd_reg;
               bus_wd_nx   = cmd_wdata;
               if (cmd_write) begin
                  if (cmd_reg >= GPIO_OUT0) begin
                     bus_we_nx = 1'b1;
                     state_nx  = WRITE;
                  end else begin
                     // read-only target: answer at once, never touch the bus
                     rsp_valid_nx = 1'b1;
                     rsp_rdata_nx = '0;
                     rsp_err_nx   = 1'b1;
                     state_nx     = RESP;
                  end
               end else begin
                  cnt_nx   = '0;
                  state_nx = READ_WAIT;
               end
            end
         end
         WRITE: begin
            rsp_valid_nx = 1'b1;
            rsp_rdata_nx = '0;
            rsp_err_nx   = 1'b0;
            state_nx     = RESP;
         end
         READ_WAIT: begin
            if (cnt == CNT_LAST) begin
               rsp_valid_nx = 1'b1;
               rsp_rdata_nx = bus_rd;
               rsp_err_nx   = 1'b0;
               state_nx     = RESP;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_nx = 1'b0;
               state_nx     = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wd    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         bus_we    <= bus_we_nx;
         bus_addr  <= bus_addr_nx;
         bus_wd    <= bus_wd_nx;
         rsp_valid <= rsp_valid_nx;
         rsp_rdata <= rsp_rdata_nx;
         rsp_err   <= rsp_err_nx;
      end
   end

endmodule

// File: tb/tb_gpio_bus_master.sv
// Directed bench for gpio_bus_master: READ_LAT=1 instance plus a READ_LAT=3 instance.
module tb_gpio_bus_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
   logic [1:0]  cmd_reg = 2'd0;
   logic [31:0] cmd_wdata = 32'd0;

   logic        a_cmd_ready, a_rsp_valid, a_rsp_err, a_bus_we;
   logic [31:0] a_rsp_rdata, a_bus_wd, a_bus_rd;
   logic [1:0]  a_bus_addr;
   logic        b_cmd_ready, b_rsp_valid, b_rsp_err, b_bus_we;
   logic [31:0] b_rsp_rdata, b_bus_wd, b_bus_rd;
   logic [1:0]  b_bus_addr;

   logic        m_cmd_ready, m_rsp_valid, m_rsp_err, m_bus_we;
   logic [31:0] m_rsp_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign a_bus_rd = 32'hCAFE_0000 | {30'd0, a_bus_addr};
   assign b_bus_rd = 32'hCAFE_0000 | {30'd0, b_bus_addr};

   assign m_cmd_ready = sel ? b_cmd_ready : a_cmd_ready;
   assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
   assign m_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
   assign m_bus_we    = sel ? b_bus_we    : a_bus_we;
   assign m_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

   gpio_bus_master #(.DATA_W(32), .READ_LAT(1)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid & ~sel), .cmd_ready(a_cmd_ready),
      .cmd_write(cmd_write), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
      .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
      .bus_we(a_bus_we), .bus_addr(a_bus_addr), .bus_wd(a_bus_wd), .bus_rd(a_bus_rd)
   );

   gpio_bus_master #(.DATA_W(32), .READ_LAT(3)) dut3 (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid & sel), .cmd_ready(b_cmd_ready),
      .cmd_write(cmd_write), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
      .bus_we(b_bus_we), .bus_addr(b_bus_addr), .bus_wd(b_bus_wd), .bus_rd(b_bus_rd)
   );

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one command on the selected instance, wait for its response, then handshake.
   task automatic run_cmd(input logic w, input logic [1:0] r, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int wes, output logic ok);
      ok = 1'b0; wes = 0; lat = 0; rd = '0; er = 1'b0;
      for (int i = 0; i < 50 && !m_cmd_ready; i++) tick();
      cmd_valid = 1'b1; cmd_write = w; cmd_reg = r; cmd_wdata = d;
      tick();
      cmd_valid = 1'b0;
      for (int i = 1; i < 50; i++) begin
         if (m_bus_we) wes++;
         if (m_rsp_valid) begin
            lat = i; rd = m_rsp_rdata; er = m_rsp_err; ok = 1'b1;
            break;
         end
         tick();
      end
      tick();
      if (m_bus_we) wes++;
   endtask

   int          lat, wes, stable_bad, seen;
   logic [31:0] rd;
   logic        er, ok;

   int          acc_n, rsp_n, we_n, exp_we;
   logic        acc, hs;
   logic [32:0] got, expv;
   logic [32:0] exp_q[$];

   initial begin
      // reset state
      #3;
      chk("rst_cmd_ready", a_cmd_ready, 0);
      chk("rst_bus_we",    a_bus_we, 0);
      chk("rst_bus_addr",  a_bus_addr, 0);
      chk("rst_bus_wd",    a_bus_wd, 0);
      chk("rst_rsp_valid", a_rsp_valid, 0);
      chk("rst_rsp_rdata", a_rsp_rdata, 0);
      chk("rst_rsp_err",   a_rsp_err, 0);
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("idle_cmd_ready", a_cmd_ready, 1);

      // 1: write reg 2
      rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_reg = 2'd2; cmd_wdata = 32'h0000_00A5;
      tick();
      cmd_valid = 1'b0;
      chk("wr_we_on",    a_bus_we, 1);
      chk("wr_addr",     a_bus_addr, 2);
      chk("wr_wd",       a_bus_wd, 32'hA5);
      chk("wr_rv_early", a_rsp_valid, 0);
      chk("wr_busy",     a_cmd_ready, 0);
      tick();
      chk("wr_we_off", a_bus_we, 0);
      chk("wr_rv",     a_rsp_valid, 1);
      chk("wr_rdata",  a_rsp_rdata, 0);
      chk("wr_err",    a_rsp_err, 0);
      tick();
      chk("wr_rv_done", a_rsp_valid, 0);
      chk("wr_idle",    a_cmd_ready, 1);

      // 2: write to read-only reg 1
      run_cmd(1'b1, 2'd1, 32'h1234, lat, rd, er, wes, ok);
      chk("ro_ok", ok, 1);
      chk("ro_lat", lat, 1);
      chk("ro_err", er, 1);
      chk("ro_rdata", rd, 0);
      chk("ro_no_we", wes, 0);

      // 3: reads at READ_LAT=1 and READ_LAT=3
      run_cmd(1'b0, 2'd0, 32'h0, lat, rd, er, wes, ok);
      chk("rd1_ok", ok, 1);
      chk("rd1_lat", lat, 2);
      chk("rd1_rdata", rd, 32'hCAFE_0000);
      chk("rd1_err", er, 0);
      sel = 1'b1;
      run_cmd(1'b0, 2'd0, 32'h0, lat, rd, er, wes, ok);
      chk("rd3_ok", ok, 1);
      chk("rd3_lat", lat, 4);
      chk("rd3_rdata", rd, 32'hCAFE_0000);
      run_cmd(1'b0, 2'd3, 32'h0, lat, rd, er, wes, ok);
      chk("rd3_r3_rdata", rd, 32'hCAFE_0003);
      chk("rd3_r3_we", wes, 0);
      sel = 1'b0;

      // 4: backpressure with the next command already waiting
      rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_reg = 2'd3; cmd_wdata = 32'h0;
      tick();
      cmd_write = 1'b1; cmd_wdata = 32'h0000_005A;
      tick();
      chk("bp_rv", a_rsp_valid, 1);
      chk("bp_rdata", a_rsp_rdata, 32'hCAFE_0003);
      stable_bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'hCAFE_0003 || a_rsp_err !== 1'b0 ||
             a_cmd_ready !== 1'b0 || a_bus_we !== 1'b0) stable_bad++;
      end
      chk("bp_stable", stable_bad, 0);
      rsp_ready = 1'b1;
      tick();
      chk("bp_hs_rv", a_rsp_valid, 0);
      chk("bp_hs_no_accept", a_bus_we, 0);
      chk("bp_hs_ready", a_cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      chk("bp_next_we", a_bus_we, 1);
      chk("bp_next_addr", a_bus_addr, 3);
      chk("bp_next_wd", a_bus_wd, 32'h5A);
      tick();
      chk("bp_next_rv", a_rsp_valid, 1);
      tick();
      chk("bp_next_done", a_rsp_valid, 0);

      // 5a: reset during the accept cycle
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_reg = 2'd3; cmd_wdata = 32'hFF;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_acc_ready", a_cmd_ready, 0);
      chk("rst_acc_addr", a_bus_addr, 0);
      tick();
      chk("rst_acc_we", a_bus_we, 0);
      chk("rst_acc_wd", a_bus_wd, 0);
      cmd_valid = 1'b0;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (a_bus_we || a_rsp_valid) seen++;
      end
      chk("rst_acc_quiet", seen, 0);

      // 5b: reset while in WRITE
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_reg = 2'd2; cmd_wdata = 32'h77;
      tick();
      cmd_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_wr_we", a_bus_we, 0);
      chk("rst_wr_wd", a_bus_wd, 0);
      #1 rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (a_bus_we || a_rsp_valid) seen++;
      end
      chk("rst_wr_quiet", seen, 0);

      // 5c: reset in READ_WAIT on the READ_LAT=3 instance
      sel = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_reg = 2'd2;
      tick();
      cmd_valid = 1'b0;
      chk("rw_addr_pre", b_bus_addr, 2);
      tick();
      #2 rst = 1'b1;
      #1;
      chk("rst_rw_addr", b_bus_addr, 0);
      chk("rst_rw_rdata", b_rsp_rdata, 0);
      chk("rst_rw_rv", b_rsp_valid, 0);
      chk("rst_rw_ready", b_cmd_ready, 0);
      #1 rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (b_rsp_valid) seen++;
      end
      chk("rst_rw_no_rsp", seen, 0);
      sel = 1'b0;

      // 6: back-to-back random stream
      acc_n = 0; rsp_n = 0; we_n = 0; exp_we = 0;
      cmd_write = 1'($urandom); cmd_reg = 2'($urandom); cmd_wdata = $urandom;
      cmd_valid = 1'b1;
      for (int cyc = 0; cyc < 2000 && rsp_n < 16; cyc++) begin
         @(negedge clk);
         acc = cmd_valid && a_cmd_ready;
         hs  = a_rsp_valid && rsp_ready;
         got = {a_rsp_err, a_rsp_rdata};
         tick();
         if (a_bus_we) we_n++;
         if (acc) begin
            if (cmd_write) begin
               expv = {(cmd_reg < 2'd2), 32'd0};
               if (cmd_reg >= 2'd2) exp_we++;
            end else begin
               expv = {1'b0, 32'hCAFE_0000 | {30'd0, cmd_reg}};
            end
            exp_q.push_back(expv);
            acc_n++;
            if (acc_n < 16) begin
               cmd_write = 1'($urandom); cmd_reg = 2'($urandom); cmd_wdata = $urandom;
            end else begin
               cmd_valid = 1'b0;
            end
         end
         if (hs) begin
            if (exp_q.size() == 0) chk("stream_extra_rsp", got, 33'h1_FFFF_FFFF);
            else chk("stream_rsp", got, exp_q.pop_front());
            rsp_n++;
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      chk("stream_rsp_count", rsp_n, 16);
      chk("stream_acc_count", acc_n, 16);
      chk("stream_we_count", we_n, exp_we);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
